// File: rtl/sid_reg_write_rx.sv
// ============================================================================
// sid_reg_write_rx : SID-style voice/filter register file written over a
//                    slow strobed host bus (synchronised strobe, edge accept)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module sid_reg_write_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ui_in,
    input  logic [7:0]  uio_in,
    output logic [47:0] v_freq,
    output logic [35:0] v_pw,
    output logic [23:0] v_ad,
    output logic [23:0] v_sr,
    output logic [23:0] v_wav,
    output logic [10:0] f_cutoff,
    output logic [7:0]  f_res_filt,
    output logic [7:0]  f_mode_vol,
    output logic        wr_pulse,
    output logic [2:0]  gate_on,
    output logic [2:0]  gate_off
);

    localparam int NUM_VOICES = 3;

    logic       s1_q, s2_q, s3_q;
    logic       accept;
    logic [2:0] addr;
    logic [1:0] voice;
    logic [7:0] data;
    logic       wr_pulse_q;
    logic       unused_bits;

    assign addr        = ui_in[2:0];
    assign voice       = ui_in[4:3];
    assign data        = uio_in;
    assign unused_bits = ^ui_in[6:5];

    // The host bus is asynchronous to clk; only the strobe is synchronised,
    // address and data are held stable long before the synchronised edge.
    assign accept = s2_q & ~s3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            wr_pulse_q <= 1'b0;
        end else begin
            s1_q       <= ui_in[7];
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            wr_pulse_q <= accept;
        end
    end

    assign wr_pulse = wr_pulse_q;

    generate
        for (genvar n = 0; n < NUM_VOICES; n++) begin : g_voice
            localparam logic [1:0] VOICE_ID = 2'(n);

            logic        sel;
            logic [15:0] freq_q, freq_d;
            logic [11:0] pw_q, pw_d;
            logic [7:0]  ad_q, ad_d;
            logic [7:0]  sr_q, sr_d;
            logic [7:0]  wav_q, wav_d;
            logic        gate_on_q, gate_on_d;
            logic        gate_off_q, gate_off_d;

            assign sel = accept && (voice == VOICE_ID);

            always_comb begin
                freq_d     = freq_q;
                pw_d       = pw_q;
                ad_d       = ad_q;
                sr_d       = sr_q;
                wav_d      = wav_q;
                gate_on_d  = 1'b0;
                gate_off_d = 1'b0;
                if (sel) begin
                    case (addr)
                        3'd0: freq_d[7:0]  = data;
                        3'd1: freq_d[15:8] = data;
                        3'd2: pw_d[7:0]    = data;
                        3'd3: pw_d[11:8]   = data[3:0];
                        3'd4: ad_d         = data;
                        3'd5: sr_d         = data;
                        3'd6: begin
                            wav_d      = data;
                            // Gate edges are judged against the old bit0, so a
                            // rewrite of the same gate value stays silent.
                            gate_on_d  = data[0] & ~wav_q[0];
                            gate_off_d = ~data[0] & wav_q[0];
                        end
                        default: ;
                    endcase
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    freq_q     <= '0;
                    pw_q       <= '0;
                    ad_q       <= '0;
                    sr_q       <= '0;
                    wav_q      <= '0;
                    gate_on_q  <= 1'b0;
                    gate_off_q <= 1'b0;
                end else begin
                    freq_q     <= freq_d;
                    pw_q       <= pw_d;
                    ad_q       <= ad_d;
                    sr_q       <= sr_d;
                    wav_q      <= wav_d;
                    gate_on_q  <= gate_on_d;
                    gate_off_q <= gate_off_d;
                end
            end

            assign v_freq[16*n +: 16] = freq_q;
            assign v_pw[12*n +: 12]   = pw_q;
            assign v_ad[8*n +: 8]     = ad_q;
            assign v_sr[8*n +: 8]     = sr_q;
            assign v_wav[8*n +: 8]    = wav_q;
            assign gate_on[n]         = gate_on_q;
            assign gate_off[n]        = gate_off_q;
        end
    endgenerate

    logic        fsel;
    logic [10:0] cutoff_q, cutoff_d;
    logic [7:0]  res_filt_q, res_filt_d;
    logic [7:0]  mode_vol_q, mode_vol_d;

    assign fsel = accept && (voice == 2'd3);

    always_comb begin
        cutoff_d   = cutoff_q;
        res_filt_d = res_filt_q;
        mode_vol_d = mode_vol_q;
        if (fsel) begin
            case (addr)
                3'd0:    cutoff_d[2:0]  = data[2:0];
                3'd1:    cutoff_d[10:3] = data;
                3'd2:    res_filt_d     = data;
                3'd3:    mode_vol_d     = data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cutoff_q   <= '0;
            res_filt_q <= '0;
            mode_vol_q <= '0;
        end else begin
            cutoff_q   <= cutoff_d;
            res_filt_q <= res_filt_d;
            mode_vol_q <= mode_vol_d;
        end
    end

    assign f_cutoff   = cutoff_q;
    assign f_res_filt = res_filt_q;
    assign f_mode_vol = mode_vol_q;

endmodule

`default_nettype wire

// File: doc/sid_reg_write_rx.md
SID_REG_WRITE_RX -- requirements
Module: sid_reg_write_rx

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning, with clock and reset first:
- clk  in  1  system clock, 24 MHz.
- rst  in  1  asynchronous active-high reset.
- ui_in  in  8  host bus: [2:0] addr, [4:3] voice, [6:5] reserved, [7] write strobe.
- uio_in  in  8  write data.
- v_freq  out  48  voice n freq, 16 bits each, at [16n+15:16n], {freq_hi, freq_lo}.
- v_pw  out  36  voice n pulse width, 12 bits each, {pw_hi[3:0], pw_lo}.
- v_ad  out  24  voice n attack/decay byte (addr 4).
- v_sr  out  24  voice n sustain/release byte (addr 5).
- v_wav  out  24  voice n waveform/control byte (addr 6); bit0 is gate.
- f_cutoff  out  11  {fc_hi, fc_lo[2:0]}.
- f_res_filt  out  8  resonance[7:4], routing[3:0].
- f_mode_vol  out  8  mode[6:4], volume[3:0].
- wr_pulse  out  1  one-cycle pulse on each accepted write.
- gate_on  out  3  per-voice one-cycle pulse on gate 0->1.
- gate_off  out  3  per-voice one-cycle pulse on gate 1->0.

Function
REQ-003 ui_in[7] SHALL pass through a 2-flop synchroniser (s1, s2), followed by a history flop s3.
REQ-004 A write SHALL be accepted in the cycle where s2=1 and s3=0, i.e. the register updates on the 3rd rising clk edge after the strobe is first sampled high.
REQ-005 On acceptance, the block SHALL sample addr, voice and data directly from ui_in and uio_in. The host holds these stable from at least 1 cycle before strobe rise until strobe fall.
REQ-006 Holding the strobe high for any length of time SHALL produce exactly one write. Re-arming requires s2 to be observed low for at least 1 cycle.
REQ-007 Strobe pulses shorter than 1 clk period are not guaranteed to register. Pulses of 2 or more cycles high and 2 or more cycles low SHALL each register exactly once.
REQ-008 Voice 0..2 writes SHALL map as follows:
- addr0 -> freq[7:0]
- addr1 -> freq[15:8]
- addr2 -> pw[7:0]
- addr3 -> pw[11:8] from data[3:0], with data[7:4] discarded
- addr4 -> ad
- addr5 -> sr
- addr6 -> wav
- addr7 -> ignored
REQ-009 Voice 3 (filter) writes SHALL map as follows:
- addr0 -> cutoff[2:0] from data[2:0]
- addr1 -> cutoff[10:3]
- addr2 -> res_filt
- addr3 -> mode_vol
- addr4..7 -> ignored
REQ-010 wr_pulse SHALL assert for exactly the acceptance cycle of every strobe, including writes to ignored addresses.
REQ-011 Each register update SHALL be visible on the outputs in the cycle after acceptance. Unaddressed registers SHALL hold their values.
REQ-012 gate_on[n] SHALL pulse for 1 cycle in the cycle after a write changes v_wav[n] bit0 from 0 to 1. gate_off[n] SHALL pulse the same way on a 1->0 change.
REQ-013 Rewriting an unchanged gate value SHALL produce no gate pulse.
REQ-014 Writing to one voice SHALL never alter another voice's registers or gate pulses.

Reset
REQ-015 While rst=1, the following SHALL be cleared to 0 asynchronously:
- all registers
- s1, s2, s3
- wr_pulse, gate_on, gate_off
REQ-016 If reset asserts mid-write (strobe high), no write SHALL occur. After release, the still-high strobe SHALL be accepted as a new write once synchronised: s3 is 0, so a rising edge is seen.
REQ-017 All outputs SHALL be 0 in the first cycle after reset deassertion.

Verification
REQ-018 Reset, then write voice0 addr0=0x24, addr1=0x00 -> v_freq[15:0]=0x0024; other voices stay 0; two wr_pulses, each 1 cycle wide, 3 edges after strobe rise.
REQ-019 Write voice0 addr3=0xF8 -> v_pw[11:0]=0x800; then voice1 addr3=0x08 -> v_pw[23:12]=0x800 and v_pw[11:0] unchanged.
REQ-020 Filter: voice3 addr0=0x00, addr1=0x04, addr2=0x81, addr3=0x1F -> f_cutoff=32, f_res_filt=0x81, f_mode_vol=0x1F; a write to voice3 addr5 changes nothing but still pulses wr_pulse.
REQ-021 Gate sequence on voice2: wav=0x11 -> gate_on[2] single pulse; wav=0x11 again -> no pulse; wav=0x10 -> gate_off[2] single pulse.
REQ-022 Strobe held high for 100 cycles -> exactly one wr_pulse; rst asserted with strobe high, then released -> registers 0, and one new write is accepted about 3 cycles after release.
